// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared definitions for the FIFO read-side stream master:
//               FSM state encoding and the default data width.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_skid2.sv
`default_nettype none
// ============================================================================
// Module      : fifo_skid2
// Description : Two-entry {last,data} output buffer. The head entry drives the
//               stream outputs; push and pop may occur in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_skid2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_last,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_last,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] data_q [2];
    logic [1:0]       last_q;
    logic             wr_ptr;
    logic             rd_ptr;
    logic             pop_ok;
    logic [1:0]       count_nxt;

    assign pop_ok    = pop && (count != 2'd0);
    assign head_data = data_q[rd_ptr];
    assign head_last = last_q[rd_ptr];

    // Occupancy follows push/pop; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_nxt = count;
        case ({push, pop_ok})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    // Storage and pointer registers; reset clears contents so the head reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            last_q    <= 2'b00;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
        end else begin
            if (push) begin
                data_q[wr_ptr] <= push_data;
                last_q[wr_ptr] <= push_last;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count_nxt;
        end
    end

endmodule : fifo_skid2
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_reader
// Description : Read-side master for the synchronous FIFO. Pops words via
//               rd_en/empty and presents them as a valid/ready stream with
//               packet framing (m_last every pkt_len words). A 2-entry output
//               buffer hides the FIFO read latency for 1 word/clk throughput.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [LEN_W-1:0] pkt_len,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_rd_en,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    input  logic             m_ready,
    output logic             busy,
    output logic [CNT_W-1:0] words_out
);

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] iss_cnt;
    logic [LEN_W-1:0] iss_cnt_nxt;
    logic             rd_pend;
    logic             pend_last;
    logic             issue_ok;
    logic             load_len;
    logic             issue_last;
    logic             handshake;
    logic [1:0]       buf_cnt;
    logic [2:0]       occupied;
    logic [2:0]       credit_lim;

    assign handshake = m_valid && m_ready;
    assign m_valid   = (buf_cnt != 2'd0);
    assign busy      = (state != ST_IDLE) || (buf_cnt != 2'd0) || rd_pend;

    // Issue permission depends only on state; STOP finishes the open packet only.
    assign issue_ok  = (state == ST_RUN) || ((state == ST_STOP) && (iss_cnt != '0));
    assign load_len  = (state == ST_IDLE) && enable;

    // Credit: buffered plus in-flight words must leave room for the new word.
    // A head pop in the same cycle frees a slot, which is what keeps the
    // stream at one word per clock in steady state.
    assign occupied   = {1'b0, buf_cnt} + {2'b00, rd_pend};
    assign credit_lim = 3'd2 + {2'b00, handshake};
    assign fifo_rd_en = issue_ok && !fifo_empty && (occupied < credit_lim);

    // Word being issued closes the packet when it is index len_q-1 (never when unframed).
    assign issue_last = (len_q != '0) && (iss_cnt == (len_q - LEN_W'(1)));

    // Packet issue counter: cleared on session start, wraps at len_q-1, held at 0 when unframed.
    always_comb begin
        iss_cnt_nxt = iss_cnt;
        if (load_len) begin
            iss_cnt_nxt = '0;
        end else if (fifo_rd_en) begin
            if (len_q == '0 || issue_last) begin
                iss_cnt_nxt = '0;
            end else begin
                iss_cnt_nxt = iss_cnt + LEN_W'(1);
            end
        end
    end

    // Next-state logic; leaving RUN/STOP waits until the current packet is fully issued.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    if (len_q == '0 || iss_cnt_nxt == '0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (iss_cnt_nxt == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Control registers: state, sampled packet length, issue counter, read-in-flight tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            iss_cnt   <= '0;
            rd_pend   <= 1'b0;
            pend_last <= 1'b0;
        end else begin
            state     <= state_nxt;
            iss_cnt   <= iss_cnt_nxt;
            rd_pend   <= fifo_rd_en;
            pend_last <= fifo_rd_en && issue_last;
            if (load_len) begin
                len_q <= pkt_len;
            end
        end
    end

    // Statistics: total downstream handshakes, free-running modulo 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_out <= '0;
        end else if (handshake) begin
            words_out <= words_out + CNT_W'(1);
        end
    end

    // FIFO data returns one cycle after the pop and is always captured.
    fifo_skid2 #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_pend),
        .push_data (fifo_rdata),
        .push_last (pend_last),
        .pop       (handshake),
        .head_data (m_data),
        .head_last (m_last),
        .count     (buf_cnt)
    );

endmodule : fifo_stream_reader
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_stream_reader
// Description : Self-checking bench for fifo_stream_reader with an inline
//               16-deep synchronous FIFO model and a ready-driving sink.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  pkt_len = 8'd0;
    logic        fifo_empty;
    logic [15:0] fifo_rdata = 16'd0;
    logic        fifo_rd_en;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_last;
    logic        m_ready = 1'b1;
    logic        busy;
    logic [31:0] words_out;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .WIDTH (16),
        .LEN_W (8),
        .CNT_W (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .pkt_len    (pkt_len),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .busy       (busy),
        .words_out  (words_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- FIFO model (WIDTH=16, DEPTH=16, 1-cycle read latency)
    logic [15:0] fmem [16];
    logic [4:0]  fcount = 5'd0;
    logic [3:0]  fwp = 4'd0;
    logic [3:0]  frp = 4'd0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = 16'd0;
    logic        fifo_clr = 1'b0;
    int          n_pops = 0;

    assign fifo_empty = (fcount == 5'd0);

    always @(posedge clk) begin
        if (fifo_clr) begin
            fcount <= 5'd0;
            fwp    <= 4'd0;
            frp    <= 4'd0;
        end else begin
            if (fifo_rd_en) begin
                chk("rd_en_while_empty", {31'd0, fcount == 5'd0}, 32'd0);
                fifo_rdata <= fmem[frp];
                frp        <= frp + 4'd1;
                n_pops     <= n_pops + 1;
            end
            if (wr_en) begin
                fmem[fwp] <= wr_data;
                fwp       <= fwp + 4'd1;
            end
            fcount <= fcount + 5'(wr_en) - 5'(fifo_rd_en);
        end
    end

    // ---------------- reference model and sink
    logic [15:0] exp_q [$];
    int          beat_cyc [$];
    int          cyc = 0;
    int          beats = 0;
    int          sess_beats = 0;
    int          pos = 0;
    int          cur_len = 0;
    int          ready_mode = 0;
    logic        stall = 1'b0;
    logic [15:0] st_data = 16'd0;
    logic        st_last = 1'b0;

    always @(negedge clk) begin
        logic [15:0] expd;
        logic        exp_last;
        cyc++;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ~m_ready;
            2:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
        if (!rst_n) begin
            chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_words_out", words_out, 32'd0);
            beats = 0;
            stall = 1'b0;
        end else begin
            chk("words_out", words_out, beats);
            if (stall) begin
                chk("stall_valid", {31'd0, m_valid}, 32'd1);
                chk("stall_data", {16'd0, m_data}, {16'd0, st_data});
                chk("stall_last", {31'd0, m_last}, {31'd0, st_last});
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    expd = exp_q.pop_front();
                    chk("beat_data", {16'd0, m_data}, {16'd0, expd});
                end
                exp_last = (cur_len != 0) && ((pos % cur_len) == cur_len - 1);
                chk("beat_last", {31'd0, m_last}, {31'd0, exp_last});
                beat_cyc.push_back(cyc);
                beats++;
                sess_beats++;
                pos++;
            end
            stall   = m_valid && !m_ready;
            st_data = m_data;
            st_last = m_last;
        end
    end

    // ---------------- stimulus helpers
    task automatic step(input bit do_wr, input logic [15:0] data);
        @(negedge clk);
        #1;
        wr_en   = do_wr;
        wr_data = data;
        if (do_wr) exp_q.push_back(data);
    endtask

    task automatic clear_fifo();
        step(0, 16'd0);
        fifo_clr = 1'b1;
        exp_q.delete();
        step(0, 16'd0);
        fifo_clr = 1'b0;
    endtask

    task automatic start_session(input int len, input int mode);
        cur_len    = len;
        pkt_len    = 8'(len);
        pos        = 0;
        sess_beats = 0;
        ready_mode = mode;
    endtask

    task automatic wait_idle(input int budget, input bit feed, input string tag);
        int k = 0;
        while (busy === 1'b1 && k < budget) begin
            if (feed && fcount == 5'd0) step(1, 16'($urandom));
            else                        step(0, 16'd0);
            k++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_beats(input int n, input int budget, input string tag);
        int k = 0;
        while (sess_beats < n && k < budget) begin
            step(0, 16'd0);
            k++;
        end
        chk(tag, {31'd0, sess_beats >= n}, 32'd1);
    endtask

    // ---------------- watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + randomized sequence
    initial begin
        int en_cyc;
        int p0;
        int k;
        int len;
        #1 rst_n = 1'b0;
        repeat (3) step(0, 16'd0);
        rst_n = 1'b1;
        clear_fifo();

        // 1: 8 words, pkt_len=4, full-rate sink
        start_session(4, 0);
        for (int i = 1; i <= 8; i++) step(1, 16'(i));
        step(0, 16'd0);
        beat_cyc.delete();
        enable = 1'b1;
        en_cyc = cyc;
        wait_beats(8, 50, "t1_beats_timeout");
        chk("t1_first_latency", beat_cyc[0], en_cyc + 3);
        chk("t1_consecutive", beat_cyc[7], en_cyc + 10);
        enable = 1'b0;
        wait_idle(50, 0, "t1_idle_timeout");
        chk("t1_words_out", words_out, 32'd8);
        chk("t1_sess_beats", sess_beats, 32'd8);

        // 2: FIFO full, ready toggling, extra words arriving
        clear_fifo();
        start_session(3, 1);
        for (int i = 0; i < 16; i++) step(1, 16'h2000 + 16'(i));
        enable = 1'b1;
        for (int i = 0; i < 40; i++) step(fcount < 5'd16, 16'($urandom));
        enable = 1'b0;
        wait_idle(400, 1, "t2_idle_timeout");
        chk("t2_pkt_multiple", sess_beats % 3, 32'd0);

        // 3: drop enable after 2nd issue; exactly one packet leaves
        clear_fifo();
        start_session(4, 0);
        for (int i = 0; i < 8; i++) step(1, 16'h3000 + 16'(i));
        p0 = n_pops;
        enable = 1'b1;
        k = 0;
        while (n_pops - p0 < 2 && k < 50) begin step(0, 16'd0); k++; end
        enable = 1'b0;
        wait_idle(100, 0, "t3_idle_timeout");
        chk("t3_sess_beats", sess_beats, 32'd4);
        chk("t3_fifo_left", {27'd0, fcount}, 32'd4);

        // 4: as 3 with only 3 words; waits in STOPPING until a 4th arrives
        clear_fifo();
        start_session(4, 0);
        for (int i = 0; i < 3; i++) step(1, 16'h4000 + 16'(i));
        p0 = n_pops;
        enable = 1'b1;
        k = 0;
        while (n_pops - p0 < 2 && k < 50) begin step(0, 16'd0); k++; end
        enable = 1'b0;
        repeat (20) step(0, 16'd0);
        chk("t4_waiting_beats", sess_beats, 32'd3);
        chk("t4_waiting_busy", {31'd0, busy}, 32'd1);
        step(1, 16'h4003);
        wait_idle(100, 0, "t4_idle_timeout");
        chk("t4_sess_beats", sess_beats, 32'd4);

        // 5: unframed, 5 words, IDLE on the clock after enable drops
        clear_fifo();
        start_session(0, 0);
        for (int i = 0; i < 5; i++) step(1, 16'h5000 + 16'(i));
        enable = 1'b1;
        wait_beats(5, 50, "t5_beats_timeout");
        step(0, 16'd0);
        enable = 1'b0;
        step(0, 16'd0);
        chk("t5_idle_next_clk", {31'd0, busy}, 32'd0);

        // randomized sessions
        for (int s = 0; s < 6; s++) begin
            clear_fifo();
            len = int'($urandom_range(0, 5));
            start_session(len, int'($urandom_range(0, 2)));
            k = int'($urandom_range(0, 10));
            for (int i = 0; i < k; i++) step(1, 16'($urandom));
            enable = 1'b1;
            k = int'($urandom_range(10, 40));
            for (int i = 0; i < k; i++)
                step(($urandom_range(0, 2) == 0) && (fcount < 5'd16), 16'($urandom));
            enable = 1'b0;
            wait_idle(400, 1, "rnd_idle_timeout");
            if (len != 0) chk("rnd_pkt_multiple", sess_beats % len, 32'd0);
        end

        // 6: reset mid-stream with the output buffer full
        clear_fifo();
        start_session(0, 3);
        for (int i = 0; i < 16; i++) step(1, 16'h6000 + 16'(i));
        enable = 1'b1;
        repeat (10) step(0, 16'd0);
        chk("t6_pre_valid", {31'd0, m_valid}, 32'd1);
        chk("t6_pre_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, m_valid}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_words_out", words_out, 32'd0);
        enable   = 1'b0;
        fifo_clr = 1'b1;
        exp_q.delete();
        step(0, 16'd0);
        step(0, 16'd0);
        fifo_clr = 1'b0;
        rst_n    = 1'b1;
        start_session(0, 0);
        for (int i = 0; i < 4; i++) step(1, 16'hA000 + 16'(i));
        enable = 1'b1;
        wait_beats(4, 50, "t6_beats_timeout");
        enable = 1'b0;
        wait_idle(50, 0, "t6_idle_timeout");
        chk("t6_words_out", words_out, 32'd4);
        chk("t6_sess_beats", sess_beats, 32'd4);

        repeat (2) step(0, 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_fifo_stream_reader
`default_nettype wire
